int_ack_sequencer: RTL

- Priority resolver and interrupt-acknowledge sequencer for the 8259 PIC. It arbitrates unmasked IRR requests against the in-service register using the rotating priority set by the control block, and drives INT to the CPU.
- Over the two-pulse INTA cycle it sets the in-service bit, pulses clear_IRR, places the vector on the internal bus, and signals end-of-acknowledge for AEOI handling.
- Sits between the IRR latch, the control block and the data-bus buffer.

---
 rtl/int_ack_sequencer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/int_ack_sequencer.sv
// int_ack_sequencer
//   Priority resolver and INTA sequencer for an 8259-style PIC. Picks the
//   highest-priority unmasked request that outranks everything in service,
//   raises INT, and runs the two-pulse acknowledge: ISR set / IRR clear on
//   pulse 1, vector on the bus during pulse 2, end-of-ack pulse at its end.
//
// Ports
//   clk, reset               system clock, synchronous active-high reset
//   init                     ICW1 write: same as reset except the gap timer
//   irr, int_mask            request register and OCW1 mask (1 = masked)
//   priority_rotate          lowest-priority level (7 = IR0 highest)
//   auto_eoi                 clear the acknowledged ISR bit at end of pulse 2
//   vector_base              ICW2 T7..T3
//   eoi                      ISR clear bits
//   int_ack                  INTA, high during each pulse
//   INT                      interrupt request to the CPU
//   vector_out, vector_oe    {vector_base, level} and its bus enable
//   clear_IRR                one-cycle one-hot IRR clear
//   in_service_reg           ISR
//   highest_level_in_service one-hot highest-priority ISR bit
//   acknowledge_interrupt    one-hot level being acknowledged (0 = spurious)
//   end_of_ack_seq           one-cycle pulse at the end of INTA pulse 2
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request outstanding
// PEND  | INT raised, waiting for INTA pulse 1
// ACK1  | pulse 1 seen, level latched, waiting for its falling edge
// GAP   | between pulses, gap timer running
// ACK2  | pulse 2, vector driven, waiting for its falling edge

module int_ack_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init,
  input  logic [7:0] irr,
  input  logic [7:0] int_mask,
  input  logic [2:0] priority_rotate,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  input  logic [7:0] eoi,
  input  logic       int_ack,
  output logic       INT,
  output logic [7:0] vector_out,
  output logic       vector_oe,
  output logic [7:0] clear_IRR,
  output logic [7:0] in_service_reg,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] acknowledge_interrupt,
  output logic       end_of_ack_seq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_ACK1,
    S_GAP,
    S_ACK2
  } state_t;

  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT);

  // Priority-ordered view: bit 0 holds the highest-priority level,
  // i.e. level (priority_rotate + 1) mod 8. The shift is 1..8, and a
  // shift of 8 on the doubled vector is the identity rotation.
  function automatic logic [7:0] to_pri(input logic [7:0] v, input logic [3:0] sh);
    logic [15:0] t;
    t = {v, v} >> sh;
    return t[7:0];
  endfunction

  function automatic logic [7:0] from_pri(input logic [7:0] v, input logic [3:0] sh);
    logic [15:0] t;
    t = {v, v} << sh;
    return t[15:8];
  endfunction

  function automatic logic [7:0] lowest_one(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction

  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) lvl = 3'(i);
    end
    return lvl;
  endfunction

  state_t     state_q, state_d;
  logic       inta_q, inta_d;
  logic       int_q, int_d;
  logic [7:0] ack_int_q, ack_int_d;
  logic [7:0] clr_q, clr_d;
  logic       oe_q, oe_d;
  logic [7:0] vec_q, vec_d;
  logic       eoa_q, eoa_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] timer_q, timer_d;

  logic       rise, fall;
  logic [3:0] rot_sh;
  logic [7:0] cand_p, isr_top_p, win_p, winner;
  logic [7:0] set_bit, aeoi_clr;

  assign rot_sh    = {1'b0, priority_rotate} + 4'd1;
  assign cand_p    = to_pri(irr & ~int_mask, rot_sh);
  assign isr_top_p = lowest_one(to_pri(isr_q, rot_sh));
  // isr_top_p - 1 selects every strictly higher level; it wraps to all
  // ones when nothing is in service.
  assign win_p     = lowest_one(cand_p & (isr_top_p - 8'd1));
  assign winner    = from_pri(win_p, rot_sh);

  assign highest_level_in_service = from_pri(isr_top_p, rot_sh);

  assign rise = int_ack & ~inta_q;
  assign fall = ~int_ack & inta_q;

  always_comb begin
    state_d   = state_q;
    inta_d    = int_ack;
    int_d     = int_q;
    // The acknowledged level stays visible during the end-of-ack pulse.
    ack_int_d = eoa_q ? 8'h00 : ack_int_q;
    clr_d     = 8'h00;
    oe_d      = oe_q;
    vec_d     = vec_q;
    eoa_d     = 1'b0;
    timer_d   = timer_q;
    set_bit   = 8'h00;
    aeoi_clr  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          // INTA without INT: acknowledge as spurious.
          ack_int_d = 8'h00;
          int_d     = 1'b0;
          state_d   = S_ACK1;
        end else if (winner != 8'h00) begin
          int_d   = 1'b1;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (rise) begin
          ack_int_d = winner;
          set_bit   = winner;
          clr_d     = winner;
          int_d     = 1'b0;
          state_d   = S_ACK1;
        end else if (winner == 8'h00) begin
          int_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ACK1: begin
        if (fall) begin
          timer_d = TIMER_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (rise) begin
          oe_d    = 1'b1;
          vec_d   = {vector_base, (ack_int_q != 8'h00) ? encode(ack_int_q) : 3'b111};
          timer_d = 8'h00;
          state_d = S_ACK2;
        end else if (timer_q <= 8'd1) begin
          ack_int_d = 8'h00;
          timer_d   = 8'h00;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      S_ACK2: begin
        if (fall) begin
          oe_d    = 1'b0;
          vec_d   = 8'h00;
          eoa_d   = 1'b1;
          if (auto_eoi) aeoi_clr = ack_int_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Set wins over a same-cycle eoi on the same bit.
    isr_d = (isr_q & ~eoi & ~aeoi_clr) | set_bit;

    // init leaves the gap timer alone; it is reloaded on every pulse-1 fall.
    if (init) begin
      state_d   = S_IDLE;
      int_d     = 1'b0;
      ack_int_d = 8'h00;
      clr_d     = 8'h00;
      oe_d      = 1'b0;
      vec_d     = 8'h00;
      eoa_d     = 1'b0;
      isr_d     = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      inta_q    <= 1'b0;
      int_q     <= 1'b0;
      ack_int_q <= 8'h00;
      clr_q     <= 8'h00;
      oe_q      <= 1'b0;
      vec_q     <= 8'h00;
      eoa_q     <= 1'b0;
      isr_q     <= 8'h00;
      timer_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      inta_q    <= inta_d;
      int_q     <= int_d;
      ack_int_q <= ack_int_d;
      clr_q     <= clr_d;
      oe_q      <= oe_d;
      vec_q     <= vec_d;
      eoa_q     <= eoa_d;
      isr_q     <= isr_d;
      timer_q   <= timer_d;
    end
  end

  assign INT                   = int_q;
  assign vector_out            = vec_q;
  assign vector_oe             = oe_q;
  assign clear_IRR             = clr_q;
  assign in_service_reg        = isr_q;
  assign acknowledge_interrupt = ack_int_q;
  assign end_of_ack_seq        = eoa_q;

endmodule
